// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring shift-subtract
// step per cycle on operand magnitudes, sign fix-up at the end, MTHI/MTLO writes when idle.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             Clock,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] Operand_A,
   input  logic [WIDTH-1:0] Operand_B,
   input  logic             Hi_Write,
   input  logic             Lo_Write,
   input  logic [WIDTH-1:0] Write_Data,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo,
   output logic [1:0]       Dbg_State
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [CW-1:0]    r_count;
   logic             r_is_div;
   logic             r_neg_a;
   logic             r_neg_q;
   logic             r_b_zero;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_m;
   logic [WIDTH-1:0] r_acc_hi;
   logic [WIDTH-1:0] r_acc_lo;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   logic             w_accept;
   logic             w_mt_ok;
   logic             w_last_step;
   logic             w_neg_a;
   logic             w_neg_b;
   logic [WIDTH-1:0] w_mag_a;
   logic [WIDTH-1:0] w_mag_b;
   logic [WIDTH:0]   w_add;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_trial;
   logic             w_ge;
   logic [WIDTH-1:0] w_diff;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0] w_fix_hi;
   logic [WIDTH-1:0] w_fix_lo;

   // Operand magnitudes; Op[0]=1 selects the unsigned variants.
   always_comb begin
      w_neg_a = ~Op[0] & Operand_A[WIDTH-1];
      w_neg_b = ~Op[0] & Operand_B[WIDTH-1];
      w_mag_a = w_neg_a ? -Operand_A : Operand_A;
      w_mag_b = w_neg_b ? -Operand_B : Operand_B;
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      Busy        = 1'b0;
      Done        = 1'b0;
      w_accept    = 1'b0;
      w_mt_ok     = 1'b0;
      w_last_step = (r_count == CW'(WIDTH - 1));
      case (r_state)
         S_IDLE, S_DONE: begin
            Done     = (r_state == S_DONE);
            w_accept = Start;
            w_mt_ok  = ~Start;
            w_next   = Start ? S_CALC : S_IDLE;
         end
         S_CALC: begin
            Busy = 1'b1;
            if (w_last_step) w_next = S_FIX;
         end
         S_FIX: begin
            Busy   = 1'b1;
            w_next = S_DONE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Mult: r_acc_lo holds the multiplier, product shifts in from the top.
   // Div: r_acc_lo holds the dividend, quotient bits shift in at the bottom.
   always_comb begin
      w_add   = r_acc_lo[0] ? {1'b0, r_m} : '0;
      w_sum   = {1'b0, r_acc_hi} + w_add;
      w_trial = {r_acc_hi, r_acc_lo[WIDTH-1]};
      w_ge    = (w_trial >= {1'b0, r_m});
      w_diff  = w_trial[WIDTH-1:0] - r_m;
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_count  <= '0;
         r_is_div <= 1'b0;
         r_neg_a  <= 1'b0;
         r_neg_q  <= 1'b0;
         r_b_zero <= 1'b0;
         r_a      <= '0;
         r_m      <= '0;
         r_acc_hi <= '0;
         r_acc_lo <= '0;
      end else if (w_accept) begin
         r_count  <= '0;
         r_is_div <= Op[1];
         r_neg_a  <= w_neg_a;
         r_neg_q  <= w_neg_a ^ w_neg_b;
         r_b_zero <= (Operand_B == '0);
         r_a      <= Operand_A;
         r_m      <= Op[1] ? w_mag_b : w_mag_a;
         r_acc_hi <= '0;
         r_acc_lo <= Op[1] ? w_mag_a : w_mag_b;
      end else if (r_state == S_CALC) begin
         r_count <= r_count + 1'b1;
         if (r_is_div) begin
            r_acc_hi <= w_ge ? w_diff : w_trial[WIDTH-1:0];
            r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_ge};
         end else begin
            r_acc_hi <= w_sum[WIDTH:1];
            r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
         end
      end
   end

   // Divide by zero bypasses the sign fix-up and returns the raw dividend in Hi.
   always_comb begin
      w_prod     = {r_acc_hi, r_acc_lo};
      w_prod_fix = r_neg_q ? -w_prod : w_prod;
      w_fix_hi   = w_prod_fix[2*WIDTH-1:WIDTH];
      w_fix_lo   = w_prod_fix[WIDTH-1:0];
      if (r_is_div) begin
         if (r_b_zero) begin
            w_fix_hi = r_a;
            w_fix_lo = '1;
         end else begin
            w_fix_hi = r_neg_a ? -r_acc_hi : r_acc_hi;
            w_fix_lo = r_neg_q ? -r_acc_lo : r_acc_lo;
         end
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (r_state == S_FIX) begin
         r_hi <= w_fix_hi;
         r_lo <= w_fix_lo;
      end else if (w_mt_ok) begin
         if (Hi_Write) r_hi <= Write_Data;
         if (Lo_Write) r_lo <= Write_Data;
      end
   end

   assign Hi        = r_hi;
   assign Lo        = r_lo;
   assign Dbg_State = r_state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed results and latency/Busy checks.
module tb_mult_div_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start_i = 1'b0;
   logic [1:0]   op_i = 2'b00;
   logic [W-1:0] a_i = '0;
   logic [W-1:0] b_i = '0;
   logic         hi_wr_i = 1'b0;
   logic         lo_wr_i = 1'b0;
   logic [W-1:0] wd_i = '0;
   logic         busy_o;
   logic         done_o;
   logic [W-1:0] hi_o;
   logic [W-1:0] lo_o;
   logic [1:0]   dbg_state_o;

   int checks = 0;
   int errors = 0;

   mult_div_unit #(.WIDTH(W)) dut (
      .Clock      (clk),
      .Reset_n    (rst_n),
      .Start      (start_i),
      .Op         (op_i),
      .Operand_A  (a_i),
      .Operand_B  (b_i),
      .Hi_Write   (hi_wr_i),
      .Lo_Write   (lo_wr_i),
      .Write_Data (wd_i),
      .Busy       (busy_o),
      .Done       (done_o),
      .Hi         (hi_o),
      .Lo         (lo_o),
      .Dbg_State  (dbg_state_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference result from plain arithmetic on the operands.
   function automatic logic [2*W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
      longint          sp;
      longint unsigned up;
      int              sq, sr;
      int unsigned     uq, ur;
      logic [W-1:0]    ones;
      ones = '1;
      case (op)
         2'b00: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            return sp;
         end
         2'b01: begin
            up = longint'(a) * longint'(b);
            return up;
         end
         2'b10: begin
            if (b == 0) return {a, ones};
            if (a == 32'h8000_0000 && b == ones) return {32'h0, 32'h8000_0000};
            sq = $signed(a) / $signed(b);
            sr = $signed(a) % $signed(b);
            return {sr, sq};
         end
         default: begin
            if (b == 0) return {a, ones};
            uq = a / b;
            ur = a % b;
            return {ur, uq};
         end
      endcase
   endfunction

   // Observable behaviour: an accepted Start yields its result WIDTH+1 edges later.
   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;
   logic [2*W-1:0] m_pend = '0;
   int           m_left = 0;
   logic         m_done = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               {m_hi, m_lo} = m_pend;
               m_done = 1'b1;
            end
         end else if (start_i) begin
            m_pend = ref_result(op_i, a_i, b_i);
            m_left = W + 1;
         end else begin
            if (hi_wr_i) m_hi = wd_i;
            if (lo_wr_i) m_lo = wd_i;
         end
      end
   end

   always @(negedge clk) begin
      check("cyc_busy", 64'(busy_o), 64'(m_left > 0));
      check("cyc_done", 64'(done_o), 64'(m_done));
      check("cyc_hi", 64'(hi_o), 64'(m_hi));
      check("cyc_lo", 64'(lo_o), 64'(m_lo));
   end

   // Called at a negedge; returns at the negedge where Done is observed.
   task automatic do_op(input string nm, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] mid_hi,
                        input logic [W-1:0] mid_lo, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo);
      int  k;
      int  busy_n;
      bit  seen;
      start_i = 1'b1; op_i = op; a_i = a; b_i = b;
      @(negedge clk);
      start_i = 1'b0; hi_wr_i = 1'b0; lo_wr_i = 1'b0;
      op_i = 2'($urandom_range(0, 3)); a_i = $urandom; b_i = $urandom;
      check({nm, "_mid_hi"}, 64'(hi_o), 64'(mid_hi));
      check({nm, "_mid_lo"}, 64'(lo_o), 64'(mid_lo));
      k = 1; busy_n = 0; seen = 1'b0;
      while (k <= 40 && !seen) begin
         if (done_o) seen = 1'b1;
         else begin
            if (busy_o) busy_n++;
            @(negedge clk);
            k++;
         end
      end
      check({nm, "_latency"}, 64'(k - 1), 64'(33));
      check({nm, "_busy_cycles"}, 64'(busy_n), 64'(33));
      check({nm, "_hi"}, 64'(hi_o), 64'(exp_hi));
      check({nm, "_lo"}, 64'(lo_o), 64'(exp_lo));
   endtask

   initial begin
      int dones;
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy_o), 64'(0));
      check("rst_done", 64'(done_o), 64'(0));
      check("rst_hi", 64'(hi_o), 64'(0));
      check("rst_lo", 64'(lo_o), 64'(0));
      #2 rst_n = 1'b1;
      @(negedge clk);

      do_op("mult_7_m3", 2'b00, 32'd7, 32'hFFFF_FFFD, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFEB,
            32'hFFFF_FFFE, 32'h0000_0001);
      do_op("mult_m1_m1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1,
            32'h0, 32'h1);
      do_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      do_op("divu_100_7", 2'b11, 32'd100, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd2, 32'd14);
      do_op("divu_by0", 2'b11, 32'd100, 32'd0, 32'd2, 32'd14, 32'h64, 32'hFFFF_FFFF);
      do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h64, 32'hFFFF_FFFF,
            32'h0, 32'h8000_0000);
      do_op("div_by0_neg", 2'b10, 32'hFFFF_FF00, 32'd0, 32'h0, 32'h8000_0000,
            32'hFFFF_FF00, 32'hFFFF_FFFF);
      do_op("div_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FF00, 32'hFFFF_FFFF,
            32'h1, 32'hFFFF_FFFD);

      // Abort: a second Start and an MTHI during the op are ignored, then reset mid-op.
      start_i = 1'b1; op_i = 2'b01; a_i = 32'd3; b_i = 32'd5;
      @(negedge clk);
      start_i = 1'b0;
      repeat (3) @(negedge clk);
      start_i = 1'b1; op_i = 2'b11; a_i = 32'd9; b_i = 32'd2; hi_wr_i = 1'b1; wd_i = 32'hDEAD;
      @(negedge clk);
      start_i = 1'b0; hi_wr_i = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_busy_pre", 64'(busy_o), 64'(1));
      check("abort_hi_pre", 64'(hi_o), 64'(32'h1));
      check("abort_lo_pre", 64'(lo_o), 64'(32'hFFFF_FFFD));
      #2 rst_n = 1'b0;
      @(negedge clk);
      check("abort_hi_rst", 64'(hi_o), 64'(0));
      check("abort_lo_rst", 64'(lo_o), 64'(0));
      check("abort_busy_rst", 64'(busy_o), 64'(0));
      #2 rst_n = 1'b1;
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (done_o) dones++;
      end
      check("abort_no_done", 64'(dones), 64'(0));
      check("abort_idle_busy", 64'(busy_o), 64'(0));

      // MTHI / MTLO while idle, then MTLO dropped in favour of Start.
      hi_wr_i = 1'b1; wd_i = 32'h1234;
      @(negedge clk);
      hi_wr_i = 1'b0;
      check("mthi", 64'(hi_o), 64'(32'h1234));
      check("mthi_lo_kept", 64'(lo_o), 64'(0));
      hi_wr_i = 1'b1; lo_wr_i = 1'b1; wd_i = 32'h55;
      @(negedge clk);
      hi_wr_i = 1'b0; lo_wr_i = 1'b0;
      check("mt_both_hi", 64'(hi_o), 64'(32'h55));
      check("mt_both_lo", 64'(lo_o), 64'(32'h55));
      lo_wr_i = 1'b1; wd_i = 32'hAAAA;
      do_op("start_vs_mtlo", 2'b11, 32'd7, 32'd7, 32'h55, 32'h55, 32'h0, 32'h1);
      do_op("b2b_mult", 2'b00, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      do_op("b2b_multu", 2'b01, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFA,
            32'h1, 32'h0);

      // MTLO in the Done cycle is honoured.
      lo_wr_i = 1'b1; wd_i = 32'hBEEF;
      @(negedge clk);
      lo_wr_i = 1'b0;
      check("mtlo_in_done", 64'(lo_o), 64'(32'hBEEF));
      check("mtlo_in_done_hi", 64'(hi_o), 64'(32'h1));
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      errors++;
      $display("FAIL timeout actual=running required=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
